// File: rtl/breath_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : breath_pwm_pkg
//  Description : Colour codes, per-colour R/G/B levels, envelope state
//                encodings and scaling helpers. The colour sequencing FSM
//                and the breathing PWM stage both use this package.
//  Revision    : 1.0 - initial release
// ============================================================================
package breath_pwm_pkg;

    // Envelope states
    typedef enum logic [1:0] {
        ST_RISE      = 2'd0,
        ST_HIGH_HOLD = 2'd1,
        ST_FALL      = 2'd2,
        ST_LOW_HOLD  = 2'd3
    } state_t;

    // Colour codes produced by the colour FSM
    localparam logic [2:0] c_color_red    = 3'd0;
    localparam logic [2:0] c_color_orange = 3'd1;
    localparam logic [2:0] c_color_yellow = 3'd2;
    localparam logic [2:0] c_color_green  = 3'd3;
    localparam logic [2:0] c_color_blue   = 3'd4;
    localparam logic [2:0] c_color_purple = 3'd5;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_level_t;

    // Per-colour full-scale channel levels
    localparam rgb_level_t c_lvl_red    = '{r: 8'd255, g: 8'd0,   b: 8'd0};
    localparam rgb_level_t c_lvl_orange = '{r: 8'd255, g: 8'd64,  b: 8'd0};
    localparam rgb_level_t c_lvl_yellow = '{r: 8'd255, g: 8'd160, b: 8'd0};
    localparam rgb_level_t c_lvl_green  = '{r: 8'd0,   g: 8'd255, b: 8'd0};
    localparam rgb_level_t c_lvl_blue   = '{r: 8'd0,   g: 8'd0,   b: 8'd255};
    localparam rgb_level_t c_lvl_purple = '{r: 8'd128, g: 8'd0,   b: 8'd255};

    // Map a colour code to its channel levels; unused codes 6/7 fall back to red
    function automatic rgb_level_t color_levels(input logic [2:0] code);
        rgb_level_t lvl;
        case (code)
            c_color_orange: lvl = c_lvl_orange;
            c_color_yellow: lvl = c_lvl_yellow;
            c_color_green:  lvl = c_lvl_green;
            c_color_blue:   lvl = c_lvl_blue;
            c_color_purple: lvl = c_lvl_purple;
            default:        lvl = c_lvl_red;
        endcase
        return lvl;
    endfunction

    // Upper byte of the 16-bit product of two bytes: (a*b) >> 8
    function automatic logic [7:0] scale8(input logic [7:0] a, input logic [7:0] b);
        return 8'((16'(a) * 16'(b)) >> 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/breath_pwm_pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel
//  Description : One PWM output bit. Compares the shared free-running PWM
//                counter against this channel's duty and registers the
//                result; the output is held low while disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [7:0] pwm_cnt_i,
    input  logic [7:0] duty_i,
    output logic       pwm_o
);

    logic r_pwm;

    // Registered compare: on while counter < duty, forced low when disabled
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pwm <= 1'b0;
        end else if (en_i) begin
            r_pwm <= (pwm_cnt_i < duty_i);
        end else begin
            r_pwm <= 1'b0;
        end
    end

    assign pwm_o = r_pwm;

endmodule
`default_nettype wire

// File: rtl/breath_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : breath_pwm
//  Description : Breathing RGB PWM driver. A prescaler produces brightness
//                steps; a four-state envelope FSM ramps brightness up, holds,
//                ramps down and holds again. The colour code is latched at
//                the start of each breath and breath_done_o pulses for one
//                cycle at that moment to advance the upstream colour FSM.
//                Optional build macro BREATH_GAMMA_EN selects a square-law
//                envelope (env = bright*bright >> 8) instead of linear.
//  Revision    : 1.0 - initial release
// ============================================================================
module breath_pwm
    import breath_pwm_pkg::*;
#(
    parameter int STEP_DIV   = 16384,
    parameter int HOLD_STEPS = 64
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic [2:0] color_i,
    output logic [2:0] rgb_o,
    output logic       breath_done_o,
    output logic [7:0] bright_o
);

    localparam int PW = (STEP_DIV < 2) ? 1 : $clog2(STEP_DIV);
    localparam int HW = (HOLD_STEPS < 1) ? 1 : $clog2(HOLD_STEPS + 1);
    localparam logic [PW-1:0] c_presc_last = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] c_hold_last  = HW'(HOLD_STEPS);

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_bright;
    logic [HW-1:0] r_hold;
    logic [7:0]    r_pwm_cnt;
    logic [2:0]    r_color;
    logic          r_done;

    state_t        w_state_nxt;
    logic [7:0]    w_bright_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic [2:0]    w_color_nxt;
    logic          w_done_nxt;
    logic          w_step_tick;

    logic [7:0]    w_env;
    rgb_level_t    w_lvl;
    logic [7:0]    w_duty [3];
    logic [2:0]    w_rgb;

    assign w_step_tick = en_i && (r_presc == c_presc_last);

    // Envelope next-state: all movement happens only on a step tick
    always_comb begin
        w_state_nxt  = r_state;
        w_bright_nxt = r_bright;
        w_hold_nxt   = r_hold;
        w_color_nxt  = r_color;
        w_done_nxt   = 1'b0;
        if (w_step_tick) begin
            case (r_state)
                ST_RISE: begin
                    if (r_bright == 8'd255) begin
                        w_state_nxt = ST_HIGH_HOLD;
                        w_hold_nxt  = '0;
                    end else begin
                        w_bright_nxt = r_bright + 8'd1;
                    end
                end
                ST_HIGH_HOLD: begin
                    if (r_hold == c_hold_last) begin
                        w_state_nxt = ST_FALL;
                    end else begin
                        w_hold_nxt = r_hold + HW'(1);
                    end
                end
                ST_FALL: begin
                    if (r_bright == 8'd0) begin
                        w_state_nxt = ST_LOW_HOLD;
                        w_hold_nxt  = '0;
                    end else begin
                        w_bright_nxt = r_bright - 8'd1;
                    end
                end
                ST_LOW_HOLD: begin
                    // End of breath: start the next one with a freshly latched hue
                    if (r_hold == c_hold_last) begin
                        w_state_nxt = ST_RISE;
                        w_color_nxt = color_i;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_hold_nxt = r_hold + HW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_LOW_HOLD;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // Prescaler, PWM counter and envelope registers; everything freezes when disabled
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_LOW_HOLD;
            r_presc   <= '0;
            r_bright  <= 8'd0;
            r_hold    <= '0;
            r_pwm_cnt <= 8'd0;
            r_color   <= c_color_red;
            r_done    <= 1'b0;
        end else begin
            if (en_i) begin
                r_presc   <= w_step_tick ? '0 : r_presc + PW'(1);
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
                r_state   <= w_state_nxt;
                r_bright  <= w_bright_nxt;
                r_hold    <= w_hold_nxt;
                r_color   <= w_color_nxt;
            end
            r_done <= w_done_nxt;
        end
    end

`ifdef BREATH_GAMMA_EN
    assign w_env = scale8(r_bright, r_bright);
`else
    assign w_env = r_bright;
`endif

    assign w_lvl     = color_levels(r_color);
    assign w_duty[2] = scale8(w_lvl.r, w_env);
    assign w_duty[1] = scale8(w_lvl.g, w_env);
    assign w_duty[0] = scale8(w_lvl.b, w_env);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            pwm_channel u_chan (
                .clk_i     (clk_i),
                .rst_n_i   (rst_n_i),
                .en_i      (en_i),
                .pwm_cnt_i (r_pwm_cnt),
                .duty_i    (w_duty[gi]),
                .pwm_o     (w_rgb[gi])
            );
        end
    endgenerate

    assign rgb_o         = w_rgb;
    assign breath_done_o = r_done;
    assign bright_o      = r_bright;

endmodule
`default_nettype wire

// File: tb/tb_breath_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_breath_pwm
//  Description : Self-checking bench for breath_pwm with STEP_DIV=2 and
//                HOLD_STEPS=1. Expected brightness is a closed-form function
//                of the enabled-cycle count; rgb/done/bright are checked every
//                cycle, with a colour table of hand-computed full-scale duties.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_breath_pwm;

    logic       clk = 1'b0;
    logic       rst_n_i;
    logic       en_i;
    logic [2:0] color_i;
    logic [2:0] rgb_o;
    logic       breath_done_o;
    logic [7:0] bright_o;

    always #5 clk = ~clk;

    breath_pwm #(
        .STEP_DIV   (2),
        .HOLD_STEPS (1)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .en_i          (en_i),
        .color_i       (color_i),
        .rgb_o         (rgb_o),
        .breath_done_o (breath_done_o),
        .bright_o      (bright_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: enabled edges since reset and the latched colour
    int         k      = 0;
    int         cyc_no = 0;
    logic [2:0] m_col  = 3'd0;
    logic [2:0] m_rgb  = 3'd0;
    logic       m_done = 1'b0;

    typedef struct {
        logic [2:0] color;
        int         dr;
        int         dg;
        int         db;
    } vec_t;
    vec_t tbl [8];

    logic hd_active = 1'b0;
    int   hd_duty [3];

    // Brightness after n step ticks; a breath is 516 ticks starting with 2 low-hold ticks
    function automatic int bright_at(input int n);
        int q;
        if (n < 2) return 0;
        q = (n - 2) % 516;
        if (q <= 255) return q;
        if (q <= 258) return 255;
        if (q <= 513) return 513 - q;
        return 0;
    endfunction

    function automatic int level(input logic [2:0] col, input int ch);
        logic [23:0] v;
        case (col)
            3'd1:    v = {8'd255, 8'd64,  8'd0};
            3'd2:    v = {8'd255, 8'd160, 8'd0};
            3'd3:    v = {8'd0,   8'd255, 8'd0};
            3'd4:    v = {8'd0,   8'd0,   8'd255};
            3'd5:    v = {8'd128, 8'd0,   8'd255};
            default: v = {8'd255, 8'd0,   8'd0};
        endcase
        return int'(v[ch*8 +: 8]);
    endfunction

    function automatic int env_of(input int b);
`ifdef BREATH_GAMMA_EN
        return (b * b) / 256;
`else
        return b;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // One clock: capture pre-edge inputs, advance the reference, compare outputs
    task automatic cyc();
        logic       r;
        logic       e;
        logic [2:0] c;
        int         n_pre;
        int         b_pre;
        int         duty;
        int         pw;
        r = rst_n_i;
        e = en_i;
        c = color_i;
        @(posedge clk);
        #1;
        cyc_no++;
        if (!r) begin
            k      = 0;
            m_col  = 3'd0;
            m_rgb  = 3'd0;
            m_done = 1'b0;
        end else if (e) begin
            n_pre = k / 2;
            b_pre = bright_at(n_pre);
            pw    = k % 256;
            for (int ch = 0; ch < 3; ch++) begin
                duty      = (level(m_col, ch) * env_of(b_pre)) / 256;
                m_rgb[ch] = (pw < duty);
            end
            if (hd_active && b_pre == 255) begin
                chk("tbl_duty_R", 32'(rgb_o[2]), 32'(pw < hd_duty[2]));
                chk("tbl_duty_G", 32'(rgb_o[1]), 32'(pw < hd_duty[1]));
                chk("tbl_duty_B", 32'(rgb_o[0]), 32'(pw < hd_duty[0]));
            end
            m_done = 1'b0;
            if ((k % 2) == 1 && (n_pre + 1) >= 2 && ((n_pre - 1) % 516) == 0) begin
                m_done = 1'b1;
                m_col  = c;
            end
            k++;
        end else begin
            m_rgb  = 3'd0;
            m_done = 1'b0;
        end
        chk("rgb", 32'(rgb_o), 32'(m_rgb));
        chk("done", 32'(breath_done_o), 32'(m_done));
        chk("bright", 32'(bright_o), 32'(bright_at(k / 2)));
    endtask

    int  lat;
    bit  got;
    int  last_done;
    int  q;

    initial begin
`ifdef BREATH_GAMMA_EN
        tbl[0] = '{3'd0, 253, 0,   0};
        tbl[1] = '{3'd3, 0,   253, 0};
        tbl[2] = '{3'd4, 0,   0,   253};
        tbl[3] = '{3'd1, 253, 63,  0};
        tbl[4] = '{3'd2, 253, 158, 0};
        tbl[5] = '{3'd5, 127, 0,   253};
        tbl[6] = '{3'd6, 253, 0,   0};
        tbl[7] = '{3'd7, 253, 0,   0};
`else
        tbl[0] = '{3'd0, 254, 0,   0};
        tbl[1] = '{3'd3, 0,   254, 0};
        tbl[2] = '{3'd4, 0,   0,   254};
        tbl[3] = '{3'd1, 254, 63,  0};
        tbl[4] = '{3'd2, 254, 159, 0};
        tbl[5] = '{3'd5, 127, 0,   254};
        tbl[6] = '{3'd6, 254, 0,   0};
        tbl[7] = '{3'd7, 254, 0,   0};
`endif

        rst_n_i = 1'b0;
        en_i    = 1'b0;
        color_i = 3'd0;
        repeat (3) cyc();
        rst_n_i = 1'b1;
        repeat (3) cyc();

        // First pulse after enabling
        color_i = tbl[0].color;
        en_i    = 1'b1;
        lat     = 0;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc();
            lat++;
            if (breath_done_o === 1'b1) got = 1'b1;
        end
        chk("first_done_latency", got ? lat : -1, 4);
        last_done = cyc_no;

        // One breath per table entry; color_i is changed right after each latch
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                got = 1'b0;
                for (int j = 0; j < 1100 && !got; j++) begin
                    cyc();
                    if (breath_done_o === 1'b1) got = 1'b1;
                end
                chk("done_period", got ? (cyc_no - last_done) : -1, 1032);
                last_done = cyc_no;
            end
            hd_duty[2] = tbl[i].dr;
            hd_duty[1] = tbl[i].dg;
            hd_duty[0] = tbl[i].db;
            hd_active  = 1'b1;
            color_i    = tbl[(i + 1) % 8].color;
            repeat (600) cyc();
            hd_active  = 1'b0;
        end

        // Pause during the fall at bright 100, mid tick
        got = 1'b0;
        for (int j = 0; j < 1100 && !got; j++) begin
            q = (k >= 4) ? ((k / 2 - 2) % 516) : 0;
            if (q > 258 && bright_at(k / 2) == 100 && (k % 2) == 1) got = 1'b1;
            else cyc();
        end
        chk("reach_fall_100", 32'(got), 32'(1));
        en_i = 1'b0;
        repeat (100) cyc();
        chk("pause_bright", 32'(bright_o), 32'(100));
        chk("pause_rgb", 32'(rgb_o), 32'(0));
        en_i = 1'b1;
        repeat (40) cyc();

        // Reset pulse during the high hold
        got = 1'b0;
        for (int j = 0; j < 1100 && !got; j++) begin
            q = (k >= 4) ? ((k / 2 - 2) % 516) : 0;
            if (k >= 4 && (q == 256 || q == 257)) got = 1'b1;
            else cyc();
        end
        chk("reach_high_hold", 32'(got), 32'(1));
        rst_n_i = 1'b0;
        cyc();
        chk("rst_bright", 32'(bright_o), 32'(0));
        chk("rst_rgb", 32'(rgb_o), 32'(0));
        chk("rst_done", 32'(breath_done_o), 32'(0));
        rst_n_i = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc();
            lat++;
            if (breath_done_o === 1'b1) got = 1'b1;
        end
        chk("post_reset_done_latency", got ? lat : -1, 4);
        repeat (50) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
